// File: rtl/sys_defs.sv
// Shared pipeline types: mult op encoding, issue/complete packets, mult stage record.
// Helper mult_load turns an issue packet into a stage-0 record with extended operands.
package sys_defs;

    localparam int XLEN      = 32;
    localparam int PR_IDX_W  = 6;
    localparam int ROB_IDX_W = 5;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } MULT_FUNC;

    typedef struct packed {
        logic                 valid;
        MULT_FUNC             op_sel;
        logic [XLEN-1:0]      rs1_value;
        logic [XLEN-1:0]      rs2_value;
        logic [PR_IDX_W-1:0]  dest_pr;
        logic [ROB_IDX_W-1:0] rob_entry;
    } ISSUE_FU_PACKET;

    typedef struct packed {
        logic                 valid;
        logic [PR_IDX_W-1:0]  dest_pr;
        logic [XLEN-1:0]      dest_value;
        logic [ROB_IDX_W-1:0] rob_entry;
    } FU_COMPLETE_PACKET;

    typedef struct packed {
        logic                 valid;
        MULT_FUNC             op_sel;
        logic [PR_IDX_W-1:0]  dest_pr;
        logic [ROB_IDX_W-1:0] rob_entry;
        logic [63:0]          mcand;
        logic [63:0]          mplier;
        logic [63:0]          sum;
    } MULT_STAGE_PACKET;

    // Operands are widened to 64 bits so a plain modulo-2^64 product yields the full signed result.
    function automatic MULT_STAGE_PACKET mult_load(input ISSUE_FU_PACKET p);
        MULT_STAGE_PACKET r;
        logic rs1_signed;
        logic rs2_signed;
        rs1_signed  = (p.op_sel != MULHU);
        rs2_signed  = (p.op_sel == MUL) || (p.op_sel == MULH);
        r           = '0;
        r.valid     = p.valid;
        r.op_sel    = p.op_sel;
        r.dest_pr   = p.dest_pr;
        r.rob_entry = p.rob_entry;
        r.mcand     = {{32{rs1_signed & p.rs1_value[31]}}, p.rs1_value};
        r.mplier    = {{32{rs2_signed & p.rs2_value[31]}}, p.rs2_value};
        return r;
    endfunction

endpackage

// File: rtl/mult_stage.sv
// One multiplier pipeline stage: adds mcand * low STEP bits of mplier, then shifts both.
// Latency 1 cycle; holds its contents when load is low, squash clears only the valid bit.
// Backpressure: the parent decides load from the downstream advance chain.
module mult_stage
    import sys_defs::*;
#(
    parameter int STEP = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             squash,
    input  logic             load,
    input  MULT_STAGE_PACKET stage_in,
    output MULT_STAGE_PACKET stage_out
);

    logic [63:0]      partial;
    MULT_STAGE_PACKET stage_nxt;

    always_comb begin
        partial          = stage_in.mcand * {{(64-STEP){1'b0}}, stage_in.mplier[STEP-1:0]};
        stage_nxt        = stage_in;
        stage_nxt.sum    = stage_in.sum + partial;
        stage_nxt.mcand  = stage_in.mcand << STEP;
        stage_nxt.mplier = stage_in.mplier >> STEP;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stage_out <= '0;
        end else if (squash) begin
            stage_out.valid <= 1'b0;
        end else if (load) begin
            stage_out <= stage_nxt;
        end
    end

endmodule

// File: rtl/mult_fu_pipe.sv
// Pipelined RV32M multiplier, NUM_STAGES steps of 64/NUM_STAGES bits; optional MULT_FU_PERF_CNT_EN counters.
// Latency NUM_STAGES cycles from accept to fu_complete_out.valid; last stage is the output register.
// Backpressure: complete_stall freezes the last stage, bubbles still collapse, fu_ready falls when stage 0 is stuck.
module mult_fu_pipe
    import sys_defs::*;
#(
    parameter int NUM_STAGES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  ISSUE_FU_PACKET    fu_packet_in,
    input  logic              squash,
    input  logic              complete_stall,
    output logic              fu_ready,
    output FU_COMPLETE_PACKET fu_complete_out
`ifdef MULT_FU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_accept_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int STEP = 64 / NUM_STAGES;

    MULT_STAGE_PACKET        stage_q [NUM_STAGES];
    MULT_STAGE_PACKET        stage0_in;
    logic [NUM_STAGES-1:0]   advance;
    logic                    accept;

    // A stage advances if it is empty or everything below it can move.
    always_comb begin
        logic ok;
        advance = '0;
        ok      = !complete_stall;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            ok         = !stage_q[k].valid || ok;
            advance[k] = ok;
        end
    end

    assign fu_ready = advance[0];
    assign accept   = fu_packet_in.valid && fu_ready && !squash;

    always_comb begin
        stage0_in       = mult_load(fu_packet_in);
        stage0_in.valid = accept;
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        if (g == 0) begin : g_first
            mult_stage #(.STEP(STEP)) u_stage (
                .clock     (clock),
                .reset     (reset),
                .squash    (squash),
                .load      (advance[g]),
                .stage_in  (stage0_in),
                .stage_out (stage_q[g])
            );
        end else begin : g_rest
            mult_stage #(.STEP(STEP)) u_stage (
                .clock     (clock),
                .reset     (reset),
                .squash    (squash),
                .load      (advance[g]),
                .stage_in  (stage_q[g-1]),
                .stage_out (stage_q[g])
            );
        end
    end

    always_comb begin
        fu_complete_out = '0;
        if (stage_q[NUM_STAGES-1].valid) begin
            fu_complete_out.valid      = 1'b1;
            fu_complete_out.dest_pr    = stage_q[NUM_STAGES-1].dest_pr;
            fu_complete_out.rob_entry  = stage_q[NUM_STAGES-1].rob_entry;
            fu_complete_out.dest_value = (stage_q[NUM_STAGES-1].op_sel == MUL)
                                       ? stage_q[NUM_STAGES-1].sum[31:0]
                                       : stage_q[NUM_STAGES-1].sum[63:32];
        end
    end

`ifdef MULT_FU_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_accept_cnt <= '0;
            perf_stall_cnt  <= '0;
        end else begin
            if (accept) begin
                perf_accept_cnt <= perf_accept_cnt + 32'd1;
            end
            if (stage_q[0].valid && !advance[0]) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mult_fu_pipe.sv
// Directed bench for mult_fu_pipe: vector table for arithmetic/latency plus stall, squash and reset sequences.
module tb_mult_fu_pipe;
    import sys_defs::*;

    localparam int NS = 4;

    logic              clock;
    logic              reset;
    ISSUE_FU_PACKET    pkt;
    logic              squash;
    logic              complete_stall;
    logic              fu_ready;
    FU_COMPLETE_PACKET fu_complete_out;
`ifdef MULT_FU_PERF_CNT_EN
    logic [31:0]       perf_accept_cnt;
    logic [31:0]       perf_stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    mult_fu_pipe #(.NUM_STAGES(NS)) dut (
        .clock           (clock),
        .reset           (reset),
        .fu_packet_in    (pkt),
        .squash          (squash),
        .complete_stall  (complete_stall),
        .fu_ready        (fu_ready),
        .fu_complete_out (fu_complete_out)
`ifdef MULT_FU_PERF_CNT_EN
        ,
        .perf_accept_cnt (perf_accept_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        MULT_FUNC    op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input MULT_FUNC op, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] pr, input logic [4:0] rob);
        pkt.valid     = 1'b1;
        pkt.op_sel    = op;
        pkt.rs1_value = a;
        pkt.rs2_value = b;
        pkt.dest_pr   = pr;
        pkt.rob_entry = rob;
    endtask

    task automatic idle();
        pkt = '0;
    endtask

    task automatic wait_done(output int lat, output FU_COMPLETE_PACKET got);
        lat = -1;
        got = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (fu_complete_out.valid) begin
                lat = n;
                got = fu_complete_out;
                break;
            end
        end
    endtask

    initial begin
        int                lat;
        int                got_n;
        int                comp;
        FU_COMPLETE_PACKET got;
        logic [31:0]       b2b_exp [4];

        vecs[0] = '{MUL,    32'd7,          32'd6,          32'd42};
        vecs[1] = '{MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000};
        vecs[2] = '{MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
        vecs[3] = '{MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF};
        vecs[4] = '{MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1};
        vecs[5] = '{MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0};
        vecs[6] = '{MULHU,  32'h8000_0000,  32'd2,          32'd1};
        vecs[7] = '{MULHSU, 32'h8000_0000,  32'h8000_0000,  32'hC000_0000};
        vecs[8] = '{MUL,    32'h1234_5678,  32'h10,         32'h2345_6780};
        vecs[9] = '{MULH,   32'd3,          32'hFFFF_FFFE,  32'hFFFF_FFFF};

        reset          = 1'b0;
        squash         = 1'b0;
        complete_stall = 1'b0;
        idle();
        #3;
        chk("rst_ready", 64'(fu_ready), 64'd1);
        chk("rst_out", 64'(fu_complete_out), 64'd0);
        #9 reset = 1'b1;

        // Single ops: value, latency and tag echo.
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            drive(vecs[i].op, vecs[i].a, vecs[i].b, 6'(i + 3), 5'(i + 1));
            @(posedge clock); #1;
            idle();
            wait_done(lat, got);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(NS));
            chk($sformatf("vec%0d_val", i), 64'(got.dest_value), 64'(vecs[i].exp));
            chk($sformatf("vec%0d_pr", i), 64'(got.dest_pr), 64'(i + 3));
            chk($sformatf("vec%0d_rob", i), 64'(got.rob_entry), 64'(i + 1));
        end

        // Back-to-back issue into a stalled pipe, an illegal issue while full, then drain in order.
        @(posedge clock); #1;
        complete_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b2b_exp[k] = 32'(10 * (k + 1));
            drive(MUL, 32'(k + 1), 32'd10, 6'(20 + k), 5'(k));
            chk($sformatf("b2b_ready%0d", k), 64'(fu_ready), 64'd1);
            @(posedge clock); #1;
        end
        drive(MUL, 32'd100, 32'd100, 6'd63, 5'd31);
        @(negedge clock);
        chk("full_ready", 64'(fu_ready), 64'd0);
        chk("full_valid", 64'(fu_complete_out.valid), 64'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk($sformatf("stall_val%0d", c), 64'(fu_complete_out.dest_value), 64'd10);
            chk($sformatf("stall_ready%0d", c), 64'(fu_ready), 64'd0);
        end
        @(posedge clock); #1;
        idle();
        complete_stall = 1'b0;
        got_n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (fu_complete_out.valid) begin
                if (got_n < 4)
                    chk($sformatf("order%0d", got_n), 64'(fu_complete_out.dest_value), 64'(b2b_exp[got_n]));
                got_n++;
            end
        end
        chk("b2b_count", 64'(got_n), 64'd4);
        chk("idle_zero", 64'(fu_complete_out), 64'd0);

        // Squash with three ops in flight and a valid input in the same cycle.
        @(posedge clock); #1;
        for (int k = 0; k < 3; k++) begin
            drive(MUL, 32'(k + 2), 32'd3, 6'(k), 5'(k));
            @(posedge clock); #1;
        end
        drive(MUL, 32'd5, 32'd5, 6'd9, 5'd9);
        squash = 1'b1;
        comp = fu_complete_out.valid ? 1 : 0;
        @(posedge clock); #1;
        squash = 1'b0;
        idle();
        @(negedge clock);
        chk("squash_ready", 64'(fu_ready), 64'd1);
        for (int c = 0; c < 10; c++) begin
            if (fu_complete_out.valid) comp++;
            @(negedge clock);
        end
        chk("squash_nocomp", 64'(comp), 64'd0);

        // Asynchronous reset between edges with two ops in flight, then an op on the first edge after release.
        @(posedge clock); #1;
        drive(MUL, 32'd9, 32'd9, 6'd1, 5'd1);
        @(posedge clock); #1;
        drive(MUL, 32'd4, 32'd4, 6'd2, 5'd2);
        @(posedge clock); #1;
        idle();
        @(negedge clock); #2;
        reset = 1'b0;
        #1;
        chk("midrst_out", 64'(fu_complete_out), 64'd0);
        chk("midrst_ready", 64'(fu_ready), 64'd1);
        @(negedge clock); #2;
        reset = 1'b1;
        drive(MUL, 32'd11, 32'd11, 6'd33, 5'd17);
        @(posedge clock); #1;
        idle();
        wait_done(lat, got);
        chk("postrst_lat", 64'(lat), 64'(NS));
        chk("postrst_val", 64'(got.dest_value), 64'd121);
        chk("postrst_pr", 64'(got.dest_pr), 64'd33);

`ifdef MULT_FU_PERF_CNT_EN
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        complete_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(MUL, 32'(k), 32'd2, 6'(k), 5'(k));
            @(posedge clock); #1;
        end
        idle();
        @(posedge clock);
        @(posedge clock); #1;
        complete_stall = 1'b0;
        drive(MUL, 32'd1, 32'd1, 6'd5, 5'd5);
        @(posedge clock); #1;
        idle();
        repeat (12) @(negedge clock);
        chk("perf_accept", 64'(perf_accept_cnt), 64'd5);
        chk("perf_stall", 64'(perf_stall_cnt), 64'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
